// File: rtl/car_pkg.sv
// Shared types for the car warning controller.
// Warning code encodings, FSM states and priority helper.
package car_pkg;

  typedef enum logic [1:0] {
    WARN_NONE  = 2'd0,
    WARN_BELT  = 2'd1,
    WARN_DOOR  = 2'd2,
    WARN_LIGHT = 2'd3
  } warn_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    MUTED = 2'd2
  } state_t;

  // Rank of a warning: door beats belt beats lights.
  function automatic logic [1:0] prio(warn_code_t c);
    logic [1:0] r;
    r = 2'd0;
    case (c)
      WARN_DOOR:  r = 2'd3;
      WARN_BELT:  r = 2'd2;
      WARN_LIGHT: r = 2'd1;
      default:    r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One-bit sensor debouncer.
// Filtered value follows raw after DEB_CYC stable samples.
module input_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic          smp;
  logic [CW-1:0] cnt;

  // Sample raw, count consecutive disagreeing samples, adopt on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp  <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      smp <= raw;
      if (smp == filt) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        filt <= smp;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_warning_ctrl.sv
// Clocked car warning controller: debounce, belt grace,
// prioritised warnings, blinking lamp and mutable buzzer.
module car_warning_ctrl
  import car_pkg::*;
#(
  parameter int N_DOORS    = 4,
  parameter int DEB_CYC    = 16,
  parameter int GRACE_CYC  = 1000,
  parameter int BLINK_HALF = 250,
  parameter int MUTE_CYC   = 5000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DOORS-1:0] door,
  input  logic               headlight,
  input  logic               engine,
  input  logic               seatbelt,
  input  logic               brake,
  input  logic               ack,
  output logic               lamp,
  output logic               buzzer,
  output logic [1:0]         warn_code
);

  localparam int NI = N_DOORS + 4;
  localparam int GW = $clog2(GRACE_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int MW = $clog2(MUTE_CYC + 1);
  localparam logic [GW-1:0] GRACE_MAX  = GW'(GRACE_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [MW-1:0] MUTE_MAX   = MW'(MUTE_CYC);

  logic [NI-1:0] raw_v;
  logic [NI-1:0] filt_v;

  assign raw_v = {brake, seatbelt, engine, headlight, door};

  for (genvar i = 0; i < NI; i++) begin : g_deb
    input_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_v[i]),
      .filt (filt_v[i])
    );
  end

  logic [N_DOORS-1:0] door_f;
  logic hl_f, en_f, sb_f, br_f;

  assign door_f = filt_v[N_DOORS-1:0];
  assign hl_f   = filt_v[N_DOORS];
  assign en_f   = filt_v[N_DOORS+1];
  assign sb_f   = filt_v[N_DOORS+2];
  assign br_f   = filt_v[N_DOORS+3];

  logic [GW-1:0] grace;
  logic          expired;
  logic          c_door, c_belt, c_light, any_c;
  warn_code_t    cur_code;

  assign expired = (grace == GRACE_MAX);
  assign c_door  = en_f & (|door_f) & ~br_f;
  assign c_belt  = en_f & ~sb_f & expired;
  assign c_light = ~en_f & hl_f & (|door_f);
  assign any_c   = c_door | c_belt | c_light;

  // Highest-priority active condition.
  always_comb begin
    cur_code = WARN_NONE;
    priority case (1'b1)
      c_door:  cur_code = WARN_DOOR;
      c_belt:  cur_code = WARN_BELT;
      c_light: cur_code = WARN_LIGHT;
      default: cur_code = WARN_NONE;
    endcase
  end

  // Belt grace timer: saturates while belt is open with engine on.
  always_ff @(posedge clk) begin
    if (rst) begin
      grace <= '0;
    end else if (!en_f || sb_f) begin
      grace <= '0;
    end else if (!expired) begin
      grace <= grace + 1'b1;
    end
  end

  state_t        state;
  warn_code_t    muted_code;
  logic [BW-1:0] blink;
  logic          phase;
  logic [MW-1:0] mute_cnt;

  // FSM, blink/mute timers and registered outputs.
  // Entering WARN from IDLE starts in the lamp-on phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      muted_code <= WARN_NONE;
      blink      <= '0;
      phase      <= 1'b0;
      mute_cnt   <= '0;
      lamp       <= 1'b0;
      buzzer     <= 1'b0;
      warn_code  <= WARN_NONE;
    end else begin
      lamp      <= (state != IDLE) && any_c && phase;
      buzzer    <= (state == WARN) && any_c &&
                   ((cur_code == WARN_LIGHT) || phase);
      warn_code <= (state == IDLE) ? WARN_NONE : cur_code;

      if (state != IDLE) begin
        if (blink == BLINK_LAST) begin
          blink <= '0;
          phase <= ~phase;
        end else begin
          blink <= blink + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          blink <= '0;
          phase <= 1'b0;
          if (any_c) begin
            state <= WARN;
            phase <= 1'b1;
          end
        end
        WARN: begin
          if (!any_c) begin
            state <= IDLE;
            blink <= '0;
            phase <= 1'b0;
          end else if (ack) begin
            state      <= MUTED;
            mute_cnt   <= '0;
            muted_code <= cur_code;
          end
        end
        MUTED: begin
          if (!any_c) begin
            state <= IDLE;
            blink <= '0;
            phase <= 1'b0;
          end else if (mute_cnt == MUTE_MAX ||
                       prio(cur_code) > prio(muted_code)) begin
            state <= WARN;
          end else begin
            mute_cnt <= mute_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Self-checking bench for car_warning_ctrl.
// Table vectors for steady states plus timed sequences.
module tb_car_warning_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] door;
  logic       headlight, engine, seatbelt, brake, ack;
  logic       lamp, buzzer;
  logic [1:0] warn_code;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  car_warning_ctrl #(
    .N_DOORS(2), .DEB_CYC(4), .GRACE_CYC(20),
    .BLINK_HALF(5), .MUTE_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .door(door),
    .headlight(headlight), .engine(engine),
    .seatbelt(seatbelt), .brake(brake), .ack(ack),
    .lamp(lamp), .buzzer(buzzer), .warn_code(warn_code)
  );

  typedef struct {
    logic [1:0] door;
    logic       hl, en, sb, br;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[10];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Wait up to max cycles for warn_code==c; returns cycles taken or -1.
  task automatic wait_code(input logic [1:0] c, input int max,
                           output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (warn_code == c) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_in(input logic [1:0] d, input logic hl,
                        input logic en, input logic sb, input logic br);
    door = d; headlight = hl; engine = en; seatbelt = sb; brake = br;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n, bad, hi, lo;
    tbl[0] = '{2'b00, 0, 0, 0, 0, 2'd0};
    tbl[1] = '{2'b00, 0, 1, 0, 0, 2'd1};
    tbl[2] = '{2'b01, 0, 1, 0, 0, 2'd2};
    tbl[3] = '{2'b01, 0, 1, 0, 1, 2'd1};
    tbl[4] = '{2'b01, 0, 1, 1, 1, 2'd0};
    tbl[5] = '{2'b01, 1, 0, 0, 0, 2'd3};
    tbl[6] = '{2'b10, 1, 1, 1, 0, 2'd2};
    tbl[7] = '{2'b00, 1, 0, 0, 0, 2'd0};
    tbl[8] = '{2'b11, 1, 0, 1, 1, 2'd3};
    tbl[9] = '{2'b10, 0, 0, 0, 0, 2'd0};

    // Reset with all inputs high: nothing may warn.
    rst = 1'b1; ack = 1'b0;
    set_in(2'b11, 1, 1, 1, 1);
    cyc(); cyc();
    chk("rst_lamp", lamp, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_code", warn_code, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      cyc();
      if (lamp || buzzer || warn_code != 0) bad++;
    end
    chk("all_high_quiet", bad, 0);

    // Steady-state table.
    for (int v = 0; v < 10; v++) begin
      set_in(tbl[v].door, tbl[v].hl, tbl[v].en, tbl[v].sb, tbl[v].br);
      repeat (40) cyc();
      chk($sformatf("tbl%0d_code", v), warn_code, tbl[v].code);
      if (tbl[v].code == 2'd0) begin
        chk($sformatf("tbl%0d_lamp", v), lamp, 0);
        chk($sformatf("tbl%0d_buz", v), buzzer, 0);
      end
      if (tbl[v].code == 2'd3)
        chk($sformatf("tbl%0d_buz", v), buzzer, 1);
    end

    // Belt grace timing and blink pattern.
    set_in(2'b00, 0, 0, 0, 0);
    repeat (10) cyc();
    set_in(2'b00, 0, 1, 0, 0);
    wait_code(2'd1, 40, n);
    chk("belt_latency", n, 27);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("belt_lamp%0d", k), lamp, ((k / 5) % 2 == 0) ? 1 : 0);
      chk($sformatf("belt_buz%0d", k), buzzer, ((k / 5) % 2 == 0) ? 1 : 0);
      cyc();
    end
    seatbelt = 1'b1;
    wait_code(2'd0, 7, n);
    chk("belt_clear_found", (n > 0) ? 1 : 0, 1);
    cyc();
    chk("belt_clear_lamp", lamp, 0);

    // Door glitch shorter than debounce, then a real opening.
    repeat (10) cyc();
    door = 2'b10;
    repeat (3) cyc();
    door = 2'b00;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (warn_code != 0) bad++;
    end
    chk("glitch_ignored", bad, 0);
    door = 2'b10;
    wait_code(2'd2, 10, n);
    chk("door_latency", n, 7);

    // Lights left on: steady buzzer, blinking lamp.
    set_in(2'b01, 1, 0, 0, 0);
    wait_code(2'd3, 12, n);
    chk("light_found", (n > 0) ? 1 : 0, 1);
    cyc();
    bad = 0; hi = 0; lo = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (!buzzer) bad++;
      if (lamp) hi++; else lo++;
    end
    chk("light_buz_steady", bad, 0);
    chk("light_lamp_hi", (hi > 0) ? 1 : 0, 1);
    chk("light_lamp_lo", (lo > 0) ? 1 : 0, 1);

    // Ack during belt warning mutes for the mute period.
    set_in(2'b00, 0, 1, 0, 0);
    wait_code(2'd1, 40, n);
    chk("mute_pre_belt", (n > 0) ? 1 : 0, 1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    bad = 0; hi = 0;
    for (int i = 0; i < 49; i++) begin
      cyc();
      if (buzzer) bad++;
      if (lamp) hi++;
    end
    chk("muted_buz_off", bad, 0);
    chk("muted_lamp_blinks", (hi > 0) ? 1 : 0, 1);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (buzzer) begin
        n = i;
        break;
      end
    end
    chk("mute_expiry_resume", (n > 0) ? 1 : 0, 1);

    // Mute again, then a door opening pre-empts the mute.
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc(); cyc();
    chk("remute_buz_off", buzzer, 0);
    door = 2'b01;
    wait_code(2'd2, 9, n);
    chk("preempt_code", (n > 0) ? 1 : 0, 1);
    n = -1;
    for (int i = 1; i <= 15; i++) begin
      cyc();
      if (buzzer) begin
        n = i;
        break;
      end
    end
    chk("preempt_buz_on", (n > 0) ? 1 : 0, 1);

    // Reset mid-warning silences outputs and restarts grace.
    rst = 1'b1;
    door = 2'b00;
    cyc();
    chk("midrst_lamp", lamp, 0);
    chk("midrst_buz", buzzer, 0);
    chk("midrst_code", warn_code, 0);
    rst = 1'b0;
    wait_code(2'd1, 40, n);
    chk("midrst_grace_restart", n, 27);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
